debug_bus_driver: RTL

//   Sequencer that owns the debugger's shared data bus for one transfer at a time.

---
 rtl/debug_bus_driver_pkg.sv | 13 +
 rtl/debug_bus_driver_down_counter.sv | 30 +++
 rtl/debug_bus_driver.sv | 131 +++++++++++++
 3 files changed

// File: rtl/debug_bus_driver_pkg.sv
// Shared definitions for the debugger bus driver and its arbiter.
// State encodings and the counter width.
package debug_bus_driver_pkg;

    localparam int CNT_W = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_GNT = 3'd1;
    localparam logic [2:0] ST_TURN     = 3'd2;
    localparam logic [2:0] ST_DRIVE    = 3'd3;
    localparam logic [2:0] ST_RELEASE  = 3'd4;

endpackage

// File: rtl/debug_bus_driver_down_counter.sv
// Loadable down counter with enable and zero flag.
// Saturates at zero.
module debug_down_counter
    import debug_bus_driver_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/debug_bus_driver.sv
// Debugger shared-bus sequencer: request, turnaround, hold, release.
// Optional parity output enabled by DEBUG_BUS_PARITY_EN.
module debug_bus_driver
    import debug_bus_driver_pkg::*;
#(
    parameter int size        = 32,
    parameter int TURN_CYCLES = 1,
    parameter int HOLD_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [size-1:0] req_data,
    output logic            req_ready,
    output logic            bus_req,
    input  logic            bus_gnt,
    output logic [size-1:0] bus_data_out,
    output logic            bus_oe,
    output logic            bus_parity,
    output logic            done
);

    localparam logic NO_TURN = (TURN_CYCLES == 0);
    localparam logic [CNT_W-1:0] TURN_LOAD =
        (TURN_CYCLES > 0) ? CNT_W'(TURN_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [size-1:0] word;
    logic            accept;
    logic            drive;
    logic            turn_load;
    logic            turn_zero;
    logic            hold_load;
    logic            hold_zero;

    assign accept = (state == ST_IDLE) && req_valid;

    always_comb begin
        state_nxt = state;
        turn_load = 1'b0;
        hold_load = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) state_nxt = ST_WAIT_GNT;
            end
            ST_WAIT_GNT: begin
                if (bus_gnt) begin
                    if (NO_TURN) begin
                        state_nxt = ST_DRIVE;
                        hold_load = 1'b1;
                    end else begin
                        state_nxt = ST_TURN;
                        turn_load = 1'b1;
                    end
                end
            end
            ST_TURN: begin
                if (!bus_gnt) begin
                    state_nxt = ST_WAIT_GNT;
                end else if (turn_zero) begin
                    state_nxt = ST_DRIVE;
                    hold_load = 1'b1;
                end
            end
            ST_DRIVE: begin
                // Preemption keeps the word; the hold window restarts on re-entry.
                if (!bus_gnt) begin
                    state_nxt = ST_WAIT_GNT;
                end else if (hold_zero) begin
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            word  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) word <= req_data;
        end
    end

    debug_down_counter #(.W(CNT_W)) u_turn_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (turn_load),
        .load_val (TURN_LOAD),
        .en       (state == ST_TURN),
        .zero     (turn_zero)
    );

    debug_down_counter #(.W(CNT_W)) u_hold_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .en       (state == ST_DRIVE),
        .zero     (hold_zero)
    );

    assign drive        = (state == ST_DRIVE);
    assign bus_oe       = drive;
    assign bus_data_out = drive ? word : '0;
    assign bus_req      = (state == ST_WAIT_GNT) || (state == ST_TURN) || drive;
    assign done         = (state == ST_RELEASE);
    assign req_ready    = (state == ST_IDLE);

`ifdef DEBUG_BUS_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^req_data;
        end
    end

    assign bus_parity = drive & parity_q;
`else
    assign bus_parity = 1'b0;
`endif

endmodule
